// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset PC, nop encoding and the fetch-queue entry layout.
package mips_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with a registered head; flush overrides push/pop.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [ENTRY_W-1:0]            push_entry_i,
  input  logic                          pop_i,
  output logic [$clog2(QDEPTH+1)-1:0]   count_o,
  output logic                          head_valid_o,
  output logic [ENTRY_W-1:0]            head_o
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  push_entry;
  fetch_entry_t  head_q, head_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          do_push, do_pop;

  assign push_entry = fetch_entry_t'(push_entry_i);
  assign do_pop     = pop_i & (count_q != '0);
  assign do_push    = push_i & ((count_q != CW'(QDEPTH)) | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    valid_d = (count_d != '0);
    // The new head may be the word being written this very cycle.
    if (!valid_d) begin
      head_d = '0;
    end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      head_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory and queues words for decode.
// Optional feature macro FETCH_ADDR_CHECK_EN: range-checks the PC, emits one faulting nop and halts.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_DEPTH = 4096,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        fetch_fault
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]        pc_q, pc_d;
  logic [CW-1:0]      q_count;
  logic               q_valid;
  logic [ENTRY_W-1:0] head_bits;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;
  logic               pop, push, halted, pc_fault;

  assign pop  = q_valid & id_ready;
  assign push = !redirect_valid & !halted & ((q_count < CW'(QDEPTH)) | pop);

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + (33'(IM_DEPTH) * 33'd4);

  logic halted_q, halted_d;

  assign pc_fault = (pc_q < PC_RESET) | ({1'b0, pc_q} >= PC_LIMIT);

  // A faulting fetch is delivered once; fetch then stalls until decode redirects it.
  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = 1'b0;
    end else if (push && pc_fault) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign pc_fault = 1'b0;
  assign halted   = 1'b0;
`endif

  assign push_entry = '{pc: pc_q, instr: (pc_fault ? INSTR_NOP : im_instr), fault: pc_fault};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (q_count),
    .head_valid_o (q_valid),
    .head_o       (head_bits)
  );

  assign head        = fetch_entry_t'(head_bits);
  assign im_addr     = pc_q;
  assign id_valid    = q_valid;
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  // Link value is zero while the head is empty so reset presents all-zero outputs.
  assign id_pc8      = q_valid ? (head.pc + 32'd8) : 32'd0;
  assign fetch_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          IM_DEPTH = 4096;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_RESET(PC_RESET),
    .IM_DEPTH(IM_DEPTH),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .im_addr       (im_addr),
    .im_instr      (im_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc8        (id_pc8),
    .fetch_fault   (fetch_fault)
  );

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb im_instr = imem_word(im_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ref_entry_t;

  ref_entry_t  mq[$];
  logic [31:0] m_pc = PC_RESET;
  bit          m_halted = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a >= PC_RESET) && (64'(a) < (64'(PC_RESET) + 64'(4 * IM_DEPTH)));
`else
    return (a == a);
`endif
  endfunction

  // One clock edge of the reference: redirect wins, else pop then (maybe) fetch one word.
  task automatic model_step();
    int         n;
    bit         pop;
    ref_entry_t e;
    n   = mq.size();
    pop = (n != 0) && id_ready;
    if (redirect_valid) begin
      mq.delete();
      m_pc     = redirect_pc & 32'hFFFF_FFFC;
      m_halted = 1'b0;
    end else begin
      if (pop) mq.delete(0);
      if (!m_halted && ((n < QDEPTH) || pop)) begin
        e.pc = m_pc;
        if (addr_ok(m_pc)) begin
          e.instr = imem_word(m_pc);
          e.fault = 1'b0;
        end else begin
          e.instr  = 32'h0;
          e.fault  = 1'b1;
          m_halted = 1'b1;
        end
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs();
    chk("im_addr", im_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_instr", id_instr, mq[0].instr);
      chk("id_pc8", id_pc8, mq[0].pc + 32'd8);
      chk("fetch_fault", 32'(fetch_fault), 32'(mq[0].fault));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // Asserts reset wherever the caller is in the cycle and checks the immediate response.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc8", id_pc8, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_im_addr", im_addr, PC_RESET);
    mq.delete();
    m_pc     = PC_RESET;
    m_halted = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1;
    // Streaming with decode always ready.
    id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("s1_pc", id_pc, PC_RESET + 32'(4 * i));
      chk("s1_pc8", id_pc8, PC_RESET + 32'(4 * i) + 32'd8);
    end

    // Backpressure fills the queue, then drains in order.
    id_ready = 1'b0;
    do_reset();
    repeat (5) cycle();
    chk("s2_pc_hold", im_addr, 32'h0000_3008);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("s2_order", id_pc, 32'h0000_3000 + 32'(4 * i));
      cycle();
    end

    // Redirect while full and popping, with misaligned target.
    id_ready = 1'b0;
    do_reset();
    cycle();
    cycle();
    id_ready = 1'b1;
    redirect_to(32'h0000_3103);
    chk("s3_flush", 32'(id_valid), 32'd0);
    cycle();
    chk("s3_head", id_pc, 32'h0000_3100);
    chk("s3_instr", id_instr, imem_word(32'h0000_3100));

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3200;
    cycle();
    redirect_to(32'h0000_3300);
    cycle();
    chk("s4_head", id_pc, 32'h0000_3300);
    cycle();
    chk("s4_next", id_pc, 32'h0000_3304);

    // Fetch beyond the end of instruction memory.
    redirect_to(32'h0000_7000);
    cycle();
    chk("s5_pc", id_pc, 32'h0000_7000);
`ifdef FETCH_ADDR_CHECK_EN
    chk("s5_nop", id_instr, 32'h0);
    chk("s5_fault", 32'(fetch_fault), 32'd1);
    repeat (4) cycle();
    chk("s5_halt_pc", im_addr, 32'h0000_7004);
    chk("s5_halt_empty", 32'(id_valid), 32'd0);
`else
    chk("s5_instr", id_instr, imem_word(32'h0000_7000));
    chk("s5_nofault", 32'(fetch_fault), 32'd0);
    repeat (4) cycle();
`endif
    redirect_to(32'h0000_3000);
    cycle();
    chk("s5_resume", id_pc, 32'h0000_3000);
    chk("s5_resume_fault", 32'(fetch_fault), 32'd0);

    // Reset asserted between clock edges mid-stream.
    repeat (3) cycle();
    @(negedge clk);
    do_reset();
    cycle();
    chk("s6_first", id_pc, PC_RESET);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = PC_RESET + $urandom_range(0, 32'h3FFF);
        1: redirect_pc = 32'h0000_6FF0 + $urandom_range(0, 31);
        2: redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: redirect_pc = $urandom();
      endcase
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
